legv8_mc_control: RTL and testbench

//  Multi-cycle control FSM for the LEGv8 datapath (imem, dmem, RegisterFile, ALU).

---
 rtl/legv8_pkg.sv | 53 +++++
 rtl/legv8_opcode_class.sv | 28 ++
 rtl/legv8_mc_control.sv | 162 ++++++++++++++++
 tb/tb_legv8_mc_control.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode patterns, ALU/PC select codes, FSM states, error codes.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI_HI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
  localparam logic [5:0]  OP_B_HI    = 6'b000101;

  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_ORR    = 4'b0001;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_CBZ, S_BRANCH, S_HALT
  } state_e;

  typedef struct packed {
    logic r;
    logic i;
    logic ld;
    logic st;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

  // R-type and immediate forms share the ADD/SUB selection; anything else defaults to ADD.
  function automatic logic [3:0] alu_op_for(input logic [10:0] opcode);
    if (opcode == OP_SUB || opcode[10:1] == OP_SUBI_HI) return ALU_SUB;
    else if (opcode == OP_AND) return ALU_AND;
    else if (opcode == OP_ORR) return ALU_ORR;
    else return ALU_ADD;
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier: maps IR[31:21] to one instruction class (or illegal).
module legv8_opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_t   cls_o
);

  logic r, i, ld, st, cbz, b;

  always_comb begin
    r   = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
          (opcode_i == OP_AND) || (opcode_i == OP_ORR);
    i   = (opcode_i[10:1] == OP_ADDI_HI) || (opcode_i[10:1] == OP_SUBI_HI);
    ld  = (opcode_i == OP_LDUR);
    st  = (opcode_i == OP_STUR);
    cbz = (opcode_i[10:3] == OP_CBZ_HI);
    b   = (opcode_i[10:5] == OP_B_HI);
    cls_o.r       = r;
    cls_o.i       = i;
    cls_o.ld      = ld;
    cls_o.st      = st;
    cls_o.cbz     = cbz;
    cls_o.b       = b;
    cls_o.illegal = ~(r | i | ld | st | cbz | b);
  end

endmodule

// File: rtl/legv8_mc_control.sv
// Multi-cycle LEGv8 control FSM with dmem handshake, wait timeout and retired-instruction count.
module legv8_mc_control
  import legv8_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             alu_zero,
  input  logic             dmem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg2loc,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  err_e             err_q, err_d;
  op_class_t        cls;
  logic             tmo_hit;

  legv8_opcode_class u_opcode_class (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  // Limit reached on the MEM_TIMEOUT-th ready-less cycle; a same-cycle ready still completes.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    ret_d   = ret_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls.illegal) begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end else if (cls.r)           state_d = S_EXEC_R;
        else if (cls.i)               state_d = S_EXEC_I;
        else if (cls.ld || cls.st)    state_d = S_MEM_ADDR;
        else if (cls.cbz)             state_d = S_CBZ;
        else                          state_d = S_BRANCH;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU, S_WB_MEM, S_CBZ, S_BRANCH: begin
        state_d = S_FETCH;
        ret_d   = ret_q + CNT_W'(1);
      end
      S_MEM_ADDR: begin
        tmo_d   = '0;
        state_d = cls.st ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (dmem_ready) begin
          if (state_q == S_MEM_RD) begin
            state_d = S_WB_MEM;
          end else begin
            state_d = S_FETCH;
            ret_d   = ret_q + CNT_W'(1);
          end
        end else if (tmo_hit) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      ret_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    reg2loc    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 4'b0000;
    halted     = 1'b0;
    err_code   = 2'b00;
    retired    = '0;
    if (!reset) begin
      halted   = (state_q == S_HALT);
      err_code = err_q;
      retired  = ret_q;
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_SEQ;
        end
        S_DECODE: reg2loc = cls.st | cls.cbz;
        S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
          alu_src_b = cls.i;
          alu_op    = alu_op_for(opcode);
          reg_write = (state_q == S_WB_ALU);
        end
        // Address stays on the ALU for the whole dmem access.
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
          reg2loc   = cls.st;
          mem_read  = (state_q == S_MEM_RD);
          mem_write = (state_q == S_MEM_WR);
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_CBZ: begin
          reg2loc  = 1'b1;
          alu_op   = ALU_PASS_B;
          pc_src   = PC_SRC_BR;
          pc_write = alu_zero;
        end
        S_BRANCH: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_BR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_mc_control.sv
// Randomized bench: per-instruction cycle timelines built from the instruction-class rules, checked every cycle.
module tb_legv8_mc_control;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      opcode;
  logic             alu_zero, dmem_ready;
  logic             ir_write, pc_write, reg2loc, reg_write, mem_read, mem_write;
  logic             mem_to_reg, alu_src_b, halted;
  logic [1:0]       pc_src, err_code;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] retired;

  legv8_mc_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg2loc, reg_write, mem_read, mem_write, mem_to_reg, alu_src_b;
    logic [3:0] alu_op;
    logic       halted;
    logic [1:0] err_code;
  } ctrl_t;

  typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR, K_STUR, K_CBZ, K_B, K_ILL} kind_e;

  typedef struct {
    ctrl_t c;
    bit    fetch;
    bit    rdy_care;
    bit    rdy;
    bit    cbz;
  } ent_t;

  ctrl_t            act, exp_c;
  logic [CNT_W-1:0] exp_ret;
  int               n_checks = 0, n_pass = 0;
  bit               chk_en = 0, meas_en = 0, pend_ret = 0;
  int               ilen[$];
  ent_t             tl[$];
  int               cyc = 0, last_f = 0;
  bit               have_last = 0;

  assign act = {ir_write, pc_write, pc_src, reg2loc, reg_write, mem_read, mem_write,
                mem_to_reg, alu_src_b, alu_op, halted, err_code};

  task automatic check(string name, logic [31:0] a, logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, a, e);
  endtask

  // Compare process: outputs against the model on every falling edge, plus fetch-to-fetch lengths.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", 32'(act), 32'(exp_c));
      check("retired", 32'(retired), 32'(exp_ret));
    end
    if (!meas_en) begin
      have_last = 0;
      ilen.delete();
    end else if (ir_write === 1'b1) begin
      if (have_last) ilen.push_back(cyc - last_f);
      last_f    = cyc;
      have_last = 1;
    end
    cyc++;
  end

  function automatic logic [3:0] exp_alu(kind_e k);
    case (k)
      K_SUB, K_SUBI: return 4'b0110;
      K_AND:         return 4'b0000;
      K_ORR:         return 4'b0001;
      default:       return 4'b0010;
    endcase
  endfunction

  function automatic logic [10:0] gen_op(kind_e k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      K_ADD:   return 11'b10001011000;
      K_SUB:   return 11'b11001011000;
      K_AND:   return 11'b10001010000;
      K_ORR:   return 11'b10101010000;
      K_ADDI:  return {10'b1001000100, r[0]};
      K_SUBI:  return {10'b1101000100, r[0]};
      K_LDUR:  return 11'b11111000010;
      K_STUR:  return 11'b11111000000;
      K_CBZ:   return {8'b10110100, r[2:0]};
      K_B:     return {6'b000101, r[4:0]};
      default: return 11'b11111111111;
    endcase
  endfunction

  function automatic ent_t mk(ctrl_t c, bit care = 0, bit rdy = 0, bit cbz = 0, bit fetch = 0);
    ent_t e;
    e.c = c; e.rdy_care = care; e.rdy = rdy; e.cbz = cbz; e.fetch = fetch;
    return e;
  endfunction

  task automatic push_halt(logic [1:0] err, int n);
    ctrl_t c;
    c = '0; c.halted = 1'b1; c.err_code = err;
    for (int j = 0; j < n; j++) tl.push_back(mk(c));
  endtask

  // Expected cycle-by-cycle control words of one instruction.
  task automatic build(kind_e k, int waits, bit tmo_fail, int nhalt);
    ctrl_t c;
    tl.delete();
    c = '0; c.ir_write = 1'b1; c.pc_write = 1'b1;
    tl.push_back(mk(c, 0, 0, 0, 1));
    c = '0; c.reg2loc = (k == K_STUR || k == K_CBZ);
    tl.push_back(mk(c));
    case (k)
      K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin
        c = '0; c.alu_src_b = (k == K_ADDI || k == K_SUBI); c.alu_op = exp_alu(k);
        tl.push_back(mk(c));
        c.reg_write = 1'b1;
        tl.push_back(mk(c));
      end
      K_LDUR, K_STUR: begin
        c = '0; c.alu_src_b = 1'b1; c.alu_op = 4'b0010; c.reg2loc = (k == K_STUR);
        tl.push_back(mk(c));
        if (k == K_LDUR) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        for (int w = 0; w < waits; w++) tl.push_back(mk(c, 1, 0));
        if (tmo_fail) push_halt(2'b10, nhalt);
        else begin
          tl.push_back(mk(c, 1, 1));
          if (k == K_LDUR) begin
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
            tl.push_back(mk(c));
          end
        end
      end
      K_CBZ: begin
        c = '0; c.reg2loc = 1'b1; c.alu_op = 4'b0111; c.pc_src = 2'b01;
        tl.push_back(mk(c, 0, 0, 1));
      end
      K_B: begin
        c = '0; c.pc_write = 1'b1; c.pc_src = 2'b01;
        tl.push_back(mk(c));
      end
      default: push_halt(2'b01, nhalt);
    endcase
  endtask

  task automatic run(kind_e k, int waits = 0, bit zero = 0, bit tmo_fail = 0, int nhalt = 0,
                     int stop_after = 0, int lit_ret = -1);
    logic [10:0] opc;
    opc = gen_op(k);
    build(k, waits, tmo_fail, nhalt);
    for (int j = 0; j < tl.size(); j++) begin
      if (stop_after > 0 && j >= stop_after) break;
      @(posedge clk); #1;
      reset = 1'b0;
      if (pend_ret) begin exp_ret++; pend_ret = 0; end
      opcode     = tl[j].fetch ? 11'($urandom) : opc;
      dmem_ready = tl[j].rdy_care ? tl[j].rdy : 1'($urandom);
      alu_zero   = tl[j].cbz ? zero : 1'($urandom);
      exp_c      = tl[j].c;
      if (tl[j].cbz) exp_c.pc_write = zero;
      if (j == 0 && lit_ret >= 0) begin
        #1 check("retired_literal", 32'(retired), 32'(lit_ret));
      end
    end
    if (stop_after == 0 && !tmo_fail && k != K_ILL) pend_ret = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; exp_c = '0; exp_ret = '0; pend_ret = 0; chk_en = 1;
    opcode = 11'($urandom); dmem_ready = 1'($urandom); alu_zero = 1'($urandom);
  endtask

  initial begin
    int exp_len[4];
    exp_len = '{4, 4, 7, 4};
    reset = 1'b1; opcode = '0; alu_zero = 1'b0; dmem_ready = 1'b0; exp_c = '0; exp_ret = '0;
    repeat (2) @(posedge clk);
    do_reset();

    meas_en = 1;
    run(K_ADD); run(K_ADDI); run(K_LDUR, 2); run(K_STUR, 0);
    run(K_B, 0, 0, 0, 0, 0, 4);
    check("ilen_count", 32'(ilen.size()), 32'd4);
    for (int j = 0; j < 4 && j < ilen.size(); j++) check("instr_cycles", 32'(ilen[j]), 32'(exp_len[j]));
    meas_en = 0;

    run(K_CBZ, 0, 1); run(K_CBZ, 0, 0);

    run(K_ILL, 0, 0, 0, 20);
    #1;
    check("halted_illegal", 32'(halted), 32'd1);
    check("err_illegal", 32'(err_code), 32'd1);
    do_reset();

    run(K_LDUR, 3, 0, 0, 0, 4);
    do_reset();
    run(K_B, 0, 0, 0, 0, 0, 0);

    run(K_LDUR, MEM_TIMEOUT, 0, 1, 4);
    #1 check("err_timeout", 32'(err_code), 32'd2);
    do_reset();
    run(K_LDUR, MEM_TIMEOUT - 1);
    run(K_STUR, MEM_TIMEOUT - 1);
    run(K_STUR, MEM_TIMEOUT, 0, 1, 3);
    do_reset();

    for (int j = 0; j < 17; j++) run(K_B);
    run(K_B, 0, 0, 0, 0, 0, 1);

    for (int j = 0; j < 200; j++) begin
      kind_e k;
      int    w;
      k = kind_e'($urandom_range(0, 9));
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MEM_TIMEOUT - 1)) : int'($urandom_range(0, 3));
      run(k, w, 1'($urandom));
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
